// File: rtl/processing_hw_div_pkg.sv
// Shared types and default widths for the radix-2 restoring unsigned divider.
package processing_hw_div_pkg;

  localparam int DEF_DIVIDEND_W = 25;
  localparam int DEF_DIVISOR_W  = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/processing_hw_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial
// subtract the divisor, keep the difference when it does not go negative.
module processing_hw_div_step #(
  parameter int DIVISOR_W = 13
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W+1:0] diff;
  logic                 unused_diff_bit;

  // Partial remainder is DIVISOR_W+1 bits; one extra bit carries the borrow.
  assign shifted = {rem_in, bit_in};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~diff[DIVISOR_W+1];

  // A kept difference is always below the divisor, so its top bit is zero.
  assign rem_out = q_bit ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];

  assign unused_diff_bit = diff[DIVISOR_W];

endmodule

// File: rtl/processing_hw_div_udiv_25ns_13ns.sv
// Multi-cycle unsigned divider: one quotient bit per enabled clock, MSB first,
// with a valid/ready handshake on both sides and a one-cycle divide-by-zero path.
module processing_hw_div_udiv_25ns_13ns
  import processing_hw_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIVIDEND_W - 1);

  div_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
  logic [DIVIDEND_W-2:0]   quo_q, quo_d;
  logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
  logic                    dbz_q, dbz_d;
  logic                    out_valid_q, out_valid_d;

  logic [DIVISOR_W-1:0]    rem_next;
  logic                    q_bit;
  logic [DIVIDEND_W-1:0]   quo_shift;

  // The dividend register shifts left so its MSB is always the next bit.
  processing_hw_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .divisor (dvs_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign quo_shift = {quo_q, q_bit};
  assign in_ready  = (state_q == IDLE) && ce;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;

    if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_d = dividend;
            dvs_d = divisor;
            rem_d = '0;
            quo_d = '0;
            if (divisor == '0) begin
              quotient_d  = '1;
              remainder_d = '0;
              dbz_d       = 1'b1;
              out_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = DONE;
            end else begin
              dbz_d   = 1'b0;
              cnt_d   = CNT_TOP;
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = rem_next;
          quo_d = quo_shift[DIVIDEND_W-2:0];
          dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
          if (cnt_q == '0) begin
            quotient_d  = quo_shift;
            remainder_d = rem_next;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_processing_hw_div_udiv_25ns_13ns.sv
// Self-checking bench: directed vector table, hand-written ce/reset sequences,
// and random operands checked against plain-arithmetic division.
module tb_processing_hw_div_udiv_25ns_13ns;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] dividend;
  logic [12:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] quotient;
  logic [12:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  processing_hw_div_udiv_25ns_13ns dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [24:0] a;
    logic [12:0] b;
    logic [24:0] q;
    logic [12:0] r;
    logic        dz;
    int          hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic void model(input logic [24:0] a, input logic [12:0] b,
                                output logic [24:0] q, output logic [12:0] r,
                                output logic dz);
    int unsigned ua, ub;
    ua = 32'(a);
    ub = 32'(b);
    if (ub == 0) begin
      q  = 25'h1FF_FFFF;
      r  = '0;
      dz = 1'b1;
    end else begin
      q  = 25'(ua / ub);
      r  = 13'(ua % ub);
      dz = 1'b0;
    end
  endfunction

  task automatic run_op(input logic [24:0] a, input logic [12:0] b,
                        input logic [24:0] eq, input logic [12:0] er, input logic edz,
                        input bit toggle, input int hold);
    int  edges;
    int  phase;
    int  exp_lat;
    bit  done;
    bit  busy_hi;
    bit  unstable;
    exp_lat  = (b == 0) ? 0 : 25;
    edges    = 0;
    phase    = 0;
    done     = 0;
    busy_hi  = 0;
    unstable = 0;

    @(negedge clk);
    ce        = 1'b1;
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b0;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);

    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        done = 1;
        break;
      end
      if (in_ready !== 1'b0) busy_hi = 1;
      ce       = toggle ? ((phase % 2) == 0) : 1'b1;
      phase++;
      in_valid = 1'b1;
      dividend = 25'($urandom);
      divisor  = 13'($urandom);
      @(posedge clk);
      if (ce) edges++;
    end
    ce = 1'b1;

    check("done_timeout", 32'(done), 32'd1);
    check("latency", 32'(edges), 32'(exp_lat));
    check("in_ready_busy", 32'(busy_hi), 32'd0);
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(edz));
    $display("op %0d/%0d -> q=%0d r=%0d dz=%0d latency=%0d hold=%0d toggle=%0d",
             a, b, quotient, remainder, div_by_zero, edges, hold, toggle);

    // Result must hold while the sink stalls; out_ready with ce low is ignored.
    for (int i = 0; i < hold; i++) begin
      ce        = ((i % 3) != 2);
      out_ready = ~ce;
      in_valid  = 1'b1;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq ||
          remainder !== er || div_by_zero !== edz) unstable = 1;
    end
    if (hold > 0) check("done_stable", 32'(unstable), 32'd0);

    ce        = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("out_valid_cleared", 32'(out_valid), 32'd0);
    check("in_ready_after", 32'(in_ready), 32'd1);
    check("quotient_kept", 32'(quotient), 32'(eq));
    check("dbz_kept", 32'(div_by_zero), 32'(edz));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [24:0] ra, mq;
    logic [12:0] rb, mr;
    logic        mdz;
    bit          leaked;

    vecs[0] = '{a: 25'd1000000,  b: 13'd7,    q: 25'd142857,     r: 13'd1,    dz: 1'b0, hold: 10};
    vecs[1] = '{a: 25'd33554431, b: 13'd8191, q: 25'd4096,       r: 13'd4095, dz: 1'b0, hold: 0};
    vecs[2] = '{a: 25'd12345,    b: 13'd0,    q: 25'h1FF_FFFF,   r: 13'd0,    dz: 1'b1, hold: 3};
    vecs[3] = '{a: 25'd50,       b: 13'd5,    q: 25'd10,         r: 13'd0,    dz: 1'b0, hold: 0};
    vecs[4] = '{a: 25'd0,        b: 13'd1,    q: 25'd0,          r: 13'd0,    dz: 1'b0, hold: 1};
    vecs[5] = '{a: 25'd33554431, b: 13'd1,    q: 25'd33554431,   r: 13'd0,    dz: 1'b0, hold: 0};
    vecs[6] = '{a: 25'd8190,     b: 13'd8191, q: 25'd0,          r: 13'd8190, dz: 1'b0, hold: 2};
    vecs[7] = '{a: 25'd0,        b: 13'd0,    q: 25'h1FF_FFFF,   r: 13'd0,    dz: 1'b1, hold: 0};

    reset_n   = 1'b0;
    ce        = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    reset_n = 1'b1;
    #1;
    check("in_ready_ce_low", 32'(in_ready), 32'd0);
    ce = 1'b1;
    #1;
    check("in_ready_first_ce", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0, vecs[i].hold);

    // ce toggling during the iterative phase
    run_op(25'd100, 13'd3, 25'd33, 13'd1, 1'b0, 1'b1, 0);

    // Divide by zero first so a stale all-ones quotient is visible at reset.
    run_op(25'd12345, 13'd0, 25'h1FF_FFFF, 13'd0, 1'b1, 1'b0, 0);
    @(negedge clk);
    ce       = 1'b1;
    in_valid = 1'b1;
    dividend = 25'd1000;
    divisor  = 13'd3;
    @(posedge clk);
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
    check("midcalc_rst_quotient", 32'(quotient), 32'd0);
    check("midcalc_rst_remainder", 32'(remainder), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    leaked = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaked = 1;
    end
    check("no_result_after_abort", 32'(leaked), 32'd0);
    run_op(25'd50, 13'd5, 25'd10, 13'd0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      ra = 25'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 13'd0;
        1:       rb = 13'($urandom_range(1, 20));
        default: rb = 13'($urandom);
      endcase
      model(ra, rb, mq, mr, mdz);
      run_op(ra, rb, mq, mr, mdz, ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
